// File: rtl/wishbone_master_if.sv
// Wishbone B4 pipelined bus signals between the master and its responder.
// Signal names follow the master's point of view (_o driven by the master).
interface wishbone_master_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        stall_i;
  logic        ack_i;
  logic        err_i;
  logic        rty_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    input  dat_i, stall_i, ack_i, err_i, rty_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, sel_o, dat_o,
    output dat_i, stall_i, ack_i, err_i, rty_i
  );
endinterface

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone B4 pipelined master. Accepts one core request
// at a time, runs the bus cycle with stall/ack/err/rty handling, bounded
// retries and a timeout, and returns exactly one response pulse per request.
module wishbone_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_adr_i,
  input  logic        req_we_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  wishbone_master_if.master wb
);

  // Counter widths leave headroom so the final increment never wraps.
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;

  typedef enum logic [1:0] {IDLE, REQUEST, WAIT, BACKOFF} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] rty_cnt;
  logic          accept_req;
  logic          term_seen;
  logic          tmo_hit;
  logic          retry;
  logic          fin;
  logic          fin_err;
  logic          fin_tmo;
  logic          capture;

  // Next-state, termination decoding and bus/handshake outputs.
  always_comb begin
    state_nxt   = state;
    accept_req  = 1'b0;
    term_seen   = 1'b0;
    tmo_hit     = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    retry       = 1'b0;
    fin         = 1'b0;
    fin_err     = 1'b0;
    fin_tmo     = 1'b0;
    capture     = 1'b0;
    req_ready_o = 1'b0;
    wb.cyc_o    = 1'b0;
    wb.stb_o    = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept_req = 1'b1;
          state_nxt  = REQUEST;
        end
      end
      REQUEST, WAIT: begin
        wb.cyc_o = 1'b1;
        wb.stb_o = (state == REQUEST);
        // A termination only belongs to this master once its strobe was taken.
        if (state == WAIT || !wb.stall_i)
          term_seen = wb.err_i | wb.rty_i | wb.ack_i;
        if (term_seen) begin
          if (wb.err_i) begin
            fin     = 1'b1;
            fin_err = 1'b1;
          end else if (wb.rty_i) begin
            if (rty_cnt < RW'(MAX_RETRIES)) begin
              retry     = 1'b1;
              state_nxt = BACKOFF;
            end else begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end
          end else begin
            fin     = 1'b1;
            capture = !wb.we_o;
          end
        end else if (tmo_hit) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          fin_tmo = 1'b1;
        end else if (state == REQUEST && !wb.stall_i) begin
          state_nxt = WAIT;
        end
        if (fin)
          state_nxt = IDLE;
      end
      BACKOFF: state_nxt = REQUEST;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Timeout and retry counters; the timeout restarts for every strobe issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
      rty_cnt <= '0;
    end else if (accept_req) begin
      tmo_cnt <= '0;
      rty_cnt <= '0;
    end else if (retry) begin
      tmo_cnt <= '0;
      rty_cnt <= rty_cnt + RW'(1);
    end else if (wb.cyc_o) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Request fields latched once and held for the whole transaction, retries included.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb.adr_o <= '0;
      wb.we_o  <= 1'b0;
      wb.sel_o <= '0;
      wb.dat_o <= '0;
    end else if (accept_req) begin
      wb.adr_o <= req_adr_i;
      wb.we_o  <= req_we_i;
      wb.sel_o <= req_sel_i;
      wb.dat_o <= req_dat_i;
    end
  end

  // Response pulse; read data only updates on a successful read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_o   <= 1'b0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      rsp_dat_o     <= '0;
    end else begin
      rsp_valid_o   <= fin;
      rsp_err_o     <= fin_err;
      rsp_timeout_o <= fin_tmo;
      if (capture)
        rsp_dat_o <= wb.dat_i;
    end
  end

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master with a small configurable responder.
module tb_wishbone_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready_o;
  logic [31:0] req_adr;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;

  always #5 clk = ~clk;

  wishbone_master_if wb ();

  wishbone_master #(.TIMEOUT_CYCLES(8), .MAX_RETRIES(3)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready_o),
    .req_adr_i     (req_adr),
    .req_we_i      (req_we),
    .req_sel_i     (req_sel),
    .req_dat_i     (req_dat),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_dat_o     (rsp_dat_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .wb            (wb)
  );

  // responder configuration (written by the stimulus only)
  int          cfg_stall = 0;   // stall cycles per strobe
  int          cfg_rty   = 0;   // rty answers before the final answer
  int          cfg_mode  = 0;   // 0 ack, 1 silent, 2 err+ack
  logic        late_ack  = 1'b0;
  logic        mon_en    = 1'b0;
  logic [31:0] mon_adr   = '0;
  logic [31:0] mon_dat   = '0;
  logic [3:0]  mon_sel   = '0;
  logic        mon_we    = 1'b0;

  // responder / monitor state (written by the always block only)
  logic        ack_r = 1'b0, err_r = 1'b0, rty_r = 1'b0;
  logic [31:0] rd_dat = '0;
  int          stall_used = 0, rty_used = 0;
  int          stb_cnt = 0, cyc_cnt = 0, bo_cnt = 0, wr_cnt = 0;
  int          field_bad = 0, stb_nocyc = 0, cyc_num = 0;
  logic [31:0] wr_dat = '0;
  logic [3:0]  wr_sel = '0;

  assign wb.stall_i = wb.stb_o && (stall_used < cfg_stall);
  assign wb.ack_i   = ack_r | late_ack;
  assign wb.err_i   = err_r;
  assign wb.rty_i   = rty_r;
  assign wb.dat_i   = rd_dat;

  always @(posedge clk) begin
    ack_r   <= 1'b0;
    err_r   <= 1'b0;
    rty_r   <= 1'b0;
    cyc_num <= cyc_num + 1;
    if (wb.stb_o === 1'b1) stb_cnt <= stb_cnt + 1;
    if (wb.cyc_o === 1'b1) cyc_cnt <= cyc_cnt + 1;
    if (wb.cyc_o === 1'b0 && req_ready_o === 1'b0 && rst === 1'b0) bo_cnt <= bo_cnt + 1;
    if (wb.stb_o === 1'b1 && wb.cyc_o !== 1'b1) stb_nocyc <= stb_nocyc + 1;
    if (mon_en && wb.cyc_o === 1'b1 &&
        (wb.adr_o !== mon_adr || wb.dat_o !== mon_dat || wb.sel_o !== mon_sel || wb.we_o !== mon_we))
      field_bad <= field_bad + 1;
    if (wb.stb_o && wb.stall_i) stall_used <= stall_used + 1;
    else if (!wb.stb_o) stall_used <= 0;
    if (req_ready_o) rty_used <= 0;
    if (wb.cyc_o && wb.stb_o && !wb.stall_i) begin
      if (wb.we_o) begin
        wr_cnt <= wr_cnt + 1;
        wr_dat <= wb.dat_o;
        wr_sel <= wb.sel_o;
      end
      if (cfg_mode == 1) begin
        // silent: never terminates
      end else if (rty_used < cfg_rty) begin
        rty_r    <= 1'b1;
        rty_used <= rty_used + 1;
      end else if (cfg_mode == 2) begin
        err_r <= 1'b1;
        ack_r <= 1'b1;
      end else begin
        ack_r  <= 1'b1;
        rd_dat <= (wb.adr_o == 32'h10) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {16'h0, wb.adr_o[15:0]});
      end
    end
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] sel, input logic [31:0] d);
    int n = 0;
    while (req_ready_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    req_valid = 1'b1;
    req_adr   = a;
    req_we    = we;
    req_sel   = sel;
    req_dat   = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid_o !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat, s0, c0, b0, w0, got, issued, last_cyc, bad_gap, n, err_seen, rv_seen;
    rst = 1'b1; req_valid = 1'b0; req_adr = '0; req_we = 1'b0; req_sel = '0; req_dat = '0;
    step(); step(); step();

    // reset state
    check("rst_cyc", wb.cyc_o, 0);
    check("rst_stb", wb.stb_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_rsp_tmo", rsp_timeout_o, 0);
    check("rst_rsp_dat", rsp_dat_o, 0);
    check("rst_adr", wb.adr_o, 0);
    rst = 1'b0;
    step();
    check("idle_ready", req_ready_o, 1);

    // read with one-cycle ack
    s0 = stb_cnt;
    issue(32'h10, 1'b0, 4'hF, 32'h0);
    check("rd_ready_busy", req_ready_o, 0);
    wait_rsp(lat);
    check("rd_rsp_valid", rsp_valid_o, 1);
    check("rd_latency", lat, 3);
    check("rd_dat", rsp_dat_o, 32'hDEAD_BEEF);
    check("rd_err", rsp_err_o, 0);
    check("rd_stb_cycles", stb_cnt - s0, 1);
    check("rd_ready_rsp", req_ready_o, 1);
    step();
    check("rd_pulse_end", rsp_valid_o, 0);

    // write with four stall cycles
    cfg_stall = 4;
    mon_adr = 32'h20; mon_dat = 32'h1234_5678; mon_sel = 4'hF; mon_we = 1'b1; mon_en = 1'b1;
    s0 = stb_cnt; w0 = wr_cnt;
    issue(32'h20, 1'b1, 4'hF, 32'h1234_5678);
    wait_rsp(lat);
    mon_en = 1'b0;
    check("wr_rsp_valid", rsp_valid_o, 1);
    check("wr_latency", lat, 7);
    check("wr_stb_cycles", stb_cnt - s0, 5);
    check("wr_fields_stable", field_bad, 0);
    check("wr_seen_count", wr_cnt - w0, 1);
    check("wr_seen_dat", wr_dat, 32'h1234_5678);
    check("wr_seen_sel", wr_sel, 4'hF);
    check("wr_err", rsp_err_o, 0);
    check("wr_dat_held", rsp_dat_o, 32'hDEAD_BEEF);
    cfg_stall = 0;
    step();

    // two retries then ack
    cfg_rty = 2;
    s0 = stb_cnt; b0 = bo_cnt;
    issue(32'h30, 1'b0, 4'hF, 32'h0);
    wait_rsp(lat);
    check("rty2_rsp_valid", rsp_valid_o, 1);
    check("rty2_latency", lat, 9);
    check("rty2_backoffs", bo_cnt - b0, 2);
    check("rty2_strobes", stb_cnt - s0, 3);
    check("rty2_err", rsp_err_o, 0);
    check("rty2_dat", rsp_dat_o, 32'hC0DE_0030);
    step();

    // four retries exhaust MAX_RETRIES=3
    cfg_rty = 4;
    s0 = stb_cnt; b0 = bo_cnt;
    issue(32'h40, 1'b0, 4'hF, 32'h0);
    wait_rsp(lat);
    check("rty4_rsp_valid", rsp_valid_o, 1);
    check("rty4_latency", lat, 12);
    check("rty4_err", rsp_err_o, 1);
    check("rty4_tmo", rsp_timeout_o, 0);
    check("rty4_strobes", stb_cnt - s0, 4);
    check("rty4_backoffs", bo_cnt - b0, 3);
    check("rty4_dat_held", rsp_dat_o, 32'hC0DE_0030);
    cfg_rty = 0;
    step();

    // timeout with a silent responder, then a late ack
    cfg_mode = 1;
    c0 = cyc_cnt;
    issue(32'h50, 1'b0, 4'hF, 32'h0);
    wait_rsp(lat);
    check("tmo_rsp_valid", rsp_valid_o, 1);
    check("tmo_latency", lat, 9);
    check("tmo_cyc_cycles", cyc_cnt - c0, 8);
    check("tmo_err", rsp_err_o, 1);
    check("tmo_flag", rsp_timeout_o, 1);
    late_ack = 1'b1;
    step();
    late_ack = 1'b0;
    check("tmo_late_ack_rsp", rsp_valid_o, 0);
    check("tmo_err_cleared", rsp_err_o, 0);
    check("tmo_flag_cleared", rsp_timeout_o, 0);
    step();
    check("tmo_late_ack_cyc", wb.cyc_o, 0);

    // err and ack together
    cfg_mode = 2;
    issue(32'h60, 1'b0, 4'hF, 32'h0);
    wait_rsp(lat);
    check("errack_rsp_valid", rsp_valid_o, 1);
    check("errack_err", rsp_err_o, 1);
    check("errack_tmo", rsp_timeout_o, 0);
    cfg_mode = 0;
    step();

    // 16 back-to-back reads
    got = 0; issued = 0; last_cyc = 0; bad_gap = 0; n = 0; err_seen = 0;
    while (got < 16 && n < 200) begin
      if (req_ready_o && issued < 16) begin
        req_valid = 1'b1;
        req_adr   = 32'h100 + issued;
        req_we    = 1'b0;
        req_sel   = 4'hF;
        issued++;
      end else begin
        req_valid = 1'b0;
      end
      step();
      n++;
      if (rsp_valid_o) begin
        check($sformatf("b2b_dat%0d", got), rsp_dat_o, 32'hC0DE_0100 + got);
        if (rsp_err_o) err_seen++;
        if (got > 0 && cyc_num - last_cyc != 3) bad_gap++;
        last_cyc = cyc_num;
        got++;
      end
    end
    req_valid = 1'b0;
    check("b2b_count", got, 16);
    check("b2b_gaps", bad_gap, 0);
    check("b2b_errs", err_seen, 0);
    step();

    // reset while waiting for a termination
    cfg_mode = 1;
    issue(32'h70, 1'b0, 4'hF, 32'h0);
    step();
    check("rstw_cyc_before", wb.cyc_o, 1);
    check("rstw_stb_before", wb.stb_o, 0);
    rst = 1'b1;
    step();
    check("rstw_cyc_after", wb.cyc_o, 0);
    check("rstw_stb_after", wb.stb_o, 0);
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid_o) rv_seen++;
      step();
    end
    check("rstw_no_rsp", rv_seen, 0);
    check("rstw_ready", req_ready_o, 1);
    check("stb_without_cyc", stb_nocyc, 0);
    cfg_mode = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
